// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: forward selects, writeback selects and ALU op codes.
package id_ex_stage_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] WBSEL_DMEM = 2'b00;
    localparam logic [1:0] WBSEL_ALU  = 2'b01;
    localparam logic [1:0] WBSEL_PC4  = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_COPYA = 4'b1010,
        ALU_PASSB = 4'b1011
    } alu_op_e;

    // MEM is the younger producer, so its value wins over WB.
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Per-operand forward select: picks MEM, WB or the register-file value for one EX source.
module fwd_sel
    import id_ex_stage_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_ex_rs,
    input  logic            i_gate,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic            i_mem_regwen,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic            i_wb_regwen,
    output logic [1:0]      o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hard-wired zero, so a write to it is never a real producer.
    assign w_mem_hit = i_mem_regwen && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs);
    assign w_wb_hit  = i_wb_regwen  && (i_wb_rd  != '0) && (i_wb_rd  == i_ex_rs);

    always_comb begin
        o_sel = FWD_NONE;
        if (i_gate)
            o_sel = fwd_pick(w_mem_hit, w_wb_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding selects and load-use bubble insertion.
// Defining ID_EX_PERF_EN adds the perf_stall_cnt / perf_flush_cnt counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rdata1,
    input  logic [XLEN-1:0] id_rdata2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_asel,
    input  logic            id_bsel,
    input  logic [OP_W-1:0] id_alu_op,
    input  logic [1:0]      id_wbsel,
    input  logic            id_regwen,
    input  logic            id_memrd,
    input  logic            id_memwr,
    input  logic            hold,
    input  logic            flush,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            mem_regwen,
    input  logic            wb_regwen,
    output logic            stall_o,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_asel,
    output logic            ex_bsel,
    output logic [OP_W-1:0] ex_alu_op,
    output logic [1:0]      ex_wbsel,
    output logic            ex_regwen,
    output logic            ex_memrd,
    output logic            ex_memwr,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b,
    output logic [1:0]      ex_store_fwd
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            asel;
        logic            bsel;
        logic [OP_W-1:0] alu_op;
        logic [1:0]      wbsel;
        logic            regwen;
        logic            memrd;
        logic            memwr;
    } slot_t;

    slot_t r_ex;
    slot_t w_load;
    logic  w_stall;
    logic  w_rs1_dep;
    logic  w_rs2_dep;

    // An invalid decode slot is captured as a bubble: side-effect enables are cleared.
    always_comb begin
        w_load        = '0;
        w_load.valid  = id_valid;
        w_load.pc     = id_pc;
        w_load.rdata1 = id_rdata1;
        w_load.rdata2 = id_rdata2;
        w_load.imm    = id_imm;
        w_load.rs1    = id_rs1;
        w_load.rs2    = id_rs2;
        w_load.rd     = id_rd;
        w_load.asel   = id_asel;
        w_load.bsel   = id_bsel;
        w_load.alu_op = id_alu_op;
        w_load.wbsel  = id_wbsel;
        w_load.regwen = id_regwen && id_valid;
        w_load.memrd  = id_memrd  && id_valid;
        w_load.memwr  = id_memwr  && id_valid;
    end

    assign w_rs1_dep = id_use_rs1 && (id_rs1 == r_ex.rd);
    assign w_rs2_dep = id_use_rs2 && (id_rs2 == r_ex.rd);
    assign w_stall   = r_ex.valid && r_ex.memrd && (r_ex.rd != '0) &&
                       (w_rs1_dep || w_rs2_dep) && id_valid && !flush;
    assign stall_o   = w_stall;

    // A flush outranks hold so a taken branch can never leave a stale op frozen in EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ex <= '0;
        else if (flush)
            r_ex <= '0;
        else if (hold)
            r_ex <= r_ex;
        else if (w_stall)
            r_ex <= '0;
        else
            r_ex <= w_load;
    end

    assign ex_valid  = r_ex.valid;
    assign ex_pc     = r_ex.pc;
    assign ex_rdata1 = r_ex.rdata1;
    assign ex_rdata2 = r_ex.rdata2;
    assign ex_imm    = r_ex.imm;
    assign ex_rs1    = r_ex.rs1;
    assign ex_rs2    = r_ex.rs2;
    assign ex_rd     = r_ex.rd;
    assign ex_asel   = r_ex.asel;
    assign ex_bsel   = r_ex.bsel;
    assign ex_alu_op = r_ex.alu_op;
    assign ex_wbsel  = r_ex.wbsel;
    assign ex_regwen = r_ex.regwen;
    assign ex_memrd  = r_ex.memrd;
    assign ex_memwr  = r_ex.memwr;

    // PC/imm operands must never be overridden, hence the asel/bsel gating.
    fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .i_ex_rs      (r_ex.rs1),
        .i_gate       (r_ex.valid && !r_ex.asel),
        .i_mem_rd     (mem_rd),
        .i_mem_regwen (mem_regwen),
        .i_wb_rd      (wb_rd),
        .i_wb_regwen  (wb_regwen),
        .o_sel        (forward_a)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .i_ex_rs      (r_ex.rs2),
        .i_gate       (r_ex.valid && !r_ex.bsel),
        .i_mem_rd     (mem_rd),
        .i_mem_regwen (mem_regwen),
        .i_wb_rd      (wb_rd),
        .i_wb_regwen  (wb_regwen),
        .o_sel        (forward_b)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_store (
        .i_ex_rs      (r_ex.rs2),
        .i_gate       (r_ex.valid && r_ex.memwr),
        .i_mem_rd     (mem_rd),
        .i_mem_regwen (mem_regwen),
        .i_wb_rd      (wb_rd),
        .i_wb_regwen  (wb_regwen),
        .o_sel        (ex_store_fwd)
    );

`ifdef ID_EX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // A stall only costs a cycle when the bubble actually lands, i.e. not while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (flush)
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if (!hold && w_stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage against a slot-level reference model.
// Also checks the perf counters when built with ID_EX_PERF_EN.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        asel;
        logic        bsel;
        logic [3:0]  alu_op;
        logic [1:0]  wbsel;
        logic        regwen;
        logic        memrd;
        logic        memwr;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, id_use_rs1, id_use_rs2, id_asel, id_bsel;
    logic        id_regwen, id_memrd, id_memwr, hold, flush, mem_regwen, wb_regwen;
    logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_wbsel;
    logic        stall_o, ex_valid, ex_asel, ex_bsel, ex_regwen, ex_memrd, ex_memwr;
    logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_wbsel, forward_a, forward_b, ex_store_fwd;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    slot_t       m;
    int unsigned mStall = 0;
    int unsigned mFlush = 0;
    int          nVectors = 0;
    int          nMiscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_asel(id_asel), .id_bsel(id_bsel), .id_alu_op(id_alu_op),
        .id_wbsel(id_wbsel), .id_regwen(id_regwen), .id_memrd(id_memrd),
        .id_memwr(id_memwr), .hold(hold), .flush(flush),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwen(mem_regwen), .wb_regwen(wb_regwen),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_asel(ex_asel), .ex_bsel(ex_bsel), .ex_alu_op(ex_alu_op),
        .ex_wbsel(ex_wbsel), .ex_regwen(ex_regwen), .ex_memrd(ex_memrd),
        .ex_memwr(ex_memwr), .forward_a(forward_a), .forward_b(forward_b),
        .ex_store_fwd(ex_store_fwd)
`ifdef ID_EX_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    function automatic slot_t dutSlot();
        return '{ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                 ex_asel, ex_bsel, ex_alu_op, ex_wbsel, ex_regwen, ex_memrd, ex_memwr};
    endfunction

    function automatic slot_t fromId();
        return '{id_valid, id_pc, id_rdata1, id_rdata2, id_imm, id_rs1, id_rs2, id_rd,
                 id_asel, id_bsel, id_alu_op, id_wbsel,
                 id_regwen & id_valid, id_memrd & id_valid, id_memwr & id_valid};
    endfunction

    function automatic logic expStall();
        logic dep;
        dep = (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
        return m.valid && m.memrd && (m.rd != 5'd0) && dep && id_valid && !flush;
    endfunction

    function automatic logic [1:0] expFwd(input logic [4:0] src, input logic en);
        if (!en) return 2'b00;
        if (mem_regwen && mem_rd != 5'd0 && mem_rd == src) return 2'b10;
        if (wb_regwen && wb_rd != 5'd0 && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic driveIdle();
        {id_valid, id_use_rs1, id_use_rs2, id_asel, id_bsel} = '0;
        {id_regwen, id_memrd, id_memwr, hold, flush, mem_regwen, wb_regwen} = '0;
        {id_pc, id_rdata1, id_rdata2, id_imm} = '0;
        {id_rs1, id_rs2, id_rd, mem_rd, wb_rd} = '0;
        id_alu_op = 4'd0;
        id_wbsel  = 2'd0;
    endtask

    task automatic driveInstr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic memrd, input logic memwr);
        id_valid = 1'b1; id_pc = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom;
        id_imm = $urandom; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_asel = 1'b0; id_bsel = 1'b0;
        id_alu_op = 4'b0000; id_wbsel = memrd ? 2'b00 : 2'b01;
        id_regwen = !memwr; id_memrd = memrd; id_memwr = memwr;
    endtask

    // Advance one clock; the model's next slot is computed from pre-edge inputs.
    task automatic tick();
        slot_t nxt;
        logic  st;
        st = expStall();
        if (flush)      nxt = '0;
        else if (hold)  nxt = m;
        else if (st)    nxt = '0;
        else            nxt = fromId();
        if (flush) mFlush++;
        if (!hold && st) mStall++;
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic test_reset();
        driveIdle();
        rst = 1'b1;
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        nVectors++;
        if (dutSlot() !== m) begin
            nMiscompares++;
            $display("[TB] FAIL reset_hold_slot: got %h want %h", dutSlot(), m);
        end
        rst = 1'b0;
        driveInstr(5'd2, 5'd3, 5'd5, 1'b1, 1'b0);
        tick();
        id_rs1 = 5'd5; id_memrd = 1'b0; id_rd = 5'd6;
        mem_rd = 5'd2; mem_regwen = 1'b1;
        #1;
        nVectors++;
        if (stall_o !== 1'b1 || forward_a !== 2'b10) begin
            nMiscompares++;
            $display("[TB] FAIL reset_pre_state: got stall=%b fa=%b want stall=1 fa=10", stall_o, forward_a);
        end
        #2;
        rst = 1'b1;
        m = '0;
        #1;
        nVectors++;
        if (dutSlot() !== m || forward_a !== 2'b00 || forward_b !== 2'b00 || stall_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_async: got slot=%h fa=%b fb=%b stall=%b want all zero",
                     dutSlot(), forward_a, forward_b, stall_o);
        end
        driveIdle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mStall = 0;
        mFlush = 0;
        tick();
        nVectors++;
        if (dutSlot() !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_release: got %h want 0", dutSlot());
        end
`ifdef ID_EX_PERF_EN
        nVectors++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_load_use();
        driveIdle();
        driveInstr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        driveInstr(5'd5, 5'd9, 5'd6, 1'b0, 1'b0);
        id_use_rs2 = 1'b0;
        #1;
        nVectors++;
        if (stall_o !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL loaduse_stall: got %b want 1", stall_o);
        end
        tick();
        nVectors++;
        if (ex_valid !== 1'b0 || ex_regwen !== 1'b0 || stall_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL loaduse_bubble: got valid=%b regwen=%b stall=%b want 0/0/0",
                     ex_valid, ex_regwen, stall_o);
        end
        tick();
        nVectors++;
        if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || dutSlot() !== m) begin
            nMiscompares++;
            $display("[TB] FAIL loaduse_enter: got valid=%b rs1=%0d slot=%h want 1/5 slot=%h",
                     ex_valid, ex_rs1, dutSlot(), m);
        end
`ifdef ID_EX_PERF_EN
        nVectors++;
        if (perf_stall_cnt !== 32'(mStall) || mStall != 1) begin
            nMiscompares++;
            $display("[TB] FAIL loaduse_perf: got %0d want 1", perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_forward();
        driveIdle();
        driveInstr(5'd3, 5'd7, 5'd0, 1'b0, 1'b1);
        id_bsel = 1'b1;
        tick();
        driveIdle();
        mem_rd = 5'd3; mem_regwen = 1'b1; wb_rd = 5'd3; wb_regwen = 1'b1;
        #1;
        nVectors++;
        if (forward_a !== 2'b10) begin
            nMiscompares++;
            $display("[TB] FAIL fwd_mem_prio: got %b want 10", forward_a);
        end
        mem_regwen = 1'b0;
        #1;
        nVectors++;
        if (forward_a !== 2'b01) begin
            nMiscompares++;
            $display("[TB] FAIL fwd_wb: got %b want 01", forward_a);
        end
        mem_rd = 5'd0; mem_regwen = 1'b1; wb_regwen = 1'b0;
        #1;
        nVectors++;
        if (forward_a !== 2'b00) begin
            nMiscompares++;
            $display("[TB] FAIL fwd_x0: got %b want 00", forward_a);
        end
        mem_rd = 5'd7; mem_regwen = 1'b1;
        #1;
        nVectors++;
        if (forward_b !== 2'b00 || ex_store_fwd !== 2'b10) begin
            nMiscompares++;
            $display("[TB] FAIL fwd_bsel_store: got fb=%b st=%b want 00/10", forward_b, ex_store_fwd);
        end
    endtask

    task automatic test_hold_flush();
        slot_t snap;
        driveIdle();
        driveInstr(5'd4, 5'd8, 5'd9, 1'b0, 1'b0);
        tick();
        snap = dutSlot();
        driveInstr(5'd10, 5'd11, 5'd12, 1'b0, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nVectors++;
            if (dutSlot() !== snap || snap !== m) begin
                nMiscompares++;
                $display("[TB] FAIL hold_freeze%0d: got %h want %h", i, dutSlot(), m);
            end
        end
        flush = 1'b1;
        tick();
        nVectors++;
        if (ex_valid !== 1'b0 || ex_regwen !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL hold_flush: got valid=%b regwen=%b want 0/0", ex_valid, ex_regwen);
        end
`ifdef ID_EX_PERF_EN
        nVectors++;
        if (perf_flush_cnt !== 32'(mFlush)) begin
            nMiscompares++;
            $display("[TB] FAIL flush_perf: got %0d want %0d", perf_flush_cnt, mFlush);
        end
`endif
    endtask

    task automatic test_x0_stall();
        driveIdle();
        driveInstr(5'd1, 5'd1, 5'd0, 1'b1, 1'b0);
        tick();
        driveInstr(5'd0, 5'd2, 5'd3, 1'b0, 1'b0);
        id_use_rs2 = 1'b0;
        #1;
        nVectors++;
        if (stall_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL x0_stall: got %b want 0", stall_o);
        end
        tick();
        nVectors++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
            nMiscompares++;
            $display("[TB] FAIL x0_nobubble: got valid=%b rd=%0d want 1/3", ex_valid, ex_rd);
        end
`ifdef ID_EX_PERF_EN
        nVectors++;
        if (perf_stall_cnt !== 32'(mStall)) begin
            nMiscompares++;
            $display("[TB] FAIL x0_perf: got %0d want %0d", perf_stall_cnt, mStall);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid   = ($urandom_range(0, 4) != 0);
            id_pc      = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            id_rd      = 5'($urandom_range(0, 7));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            id_asel    = 1'($urandom); id_bsel = 1'($urandom);
            id_alu_op  = 4'($urandom_range(0, 11));
            id_wbsel   = 2'($urandom);
            id_regwen  = 1'($urandom); id_memrd = 1'($urandom); id_memwr = 1'($urandom);
            hold       = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            mem_rd     = 5'($urandom_range(0, 7)); wb_rd = 5'($urandom_range(0, 7));
            mem_regwen = 1'($urandom); wb_regwen = 1'($urandom);
            #1;
            nVectors++;
            if (dutSlot() !== m) begin
                nMiscompares++;
                $display("[TB] FAIL rnd_slot@%0d: got %h want %h", i, dutSlot(), m);
            end
            nVectors++;
            if (stall_o !== expStall()) begin
                nMiscompares++;
                $display("[TB] FAIL rnd_stall@%0d: got %b want %b", i, stall_o, expStall());
            end
            nVectors++;
            if (forward_a !== expFwd(m.rs1, m.valid && !m.asel) ||
                forward_b !== expFwd(m.rs2, m.valid && !m.bsel) ||
                ex_store_fwd !== expFwd(m.rs2, m.valid && m.memwr)) begin
                nMiscompares++;
                $display("[TB] FAIL rnd_fwd@%0d: got %b/%b/%b want %b/%b/%b", i,
                         forward_a, forward_b, ex_store_fwd, expFwd(m.rs1, m.valid && !m.asel),
                         expFwd(m.rs2, m.valid && !m.bsel), expFwd(m.rs2, m.valid && m.memwr));
            end
`ifdef ID_EX_PERF_EN
            nVectors++;
            if (perf_stall_cnt !== 32'(mStall) || perf_flush_cnt !== 32'(mFlush)) begin
                nMiscompares++;
                $display("[TB] FAIL rnd_perf@%0d: got %0d/%0d want %0d/%0d", i,
                         perf_stall_cnt, perf_flush_cnt, mStall, mFlush);
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_hold_flush();
        test_x0_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
